// File: rtl/mesh_network_interface.sv
// Endpoint network interface for a mesh router LOCAL port.
// TX: core flits are queued and injected as {addr,data} router flits.
// RX: ejected flits are queued for the core, with a destination check against this node.
// Also provides saturating flit counters, a sticky misroute flag and an injection-stall watchdog.
`timescale 1ns/1ps

module mesh_network_interface #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int TX_DEPTH     = 4,
    parameter int RX_DEPTH     = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter int STALL_LIMIT  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [X_ADDR_WIDTH-1:0] local_x_addr,
    input  logic [Y_ADDR_WIDTH-1:0] local_y_addr,
    input  logic                    tx_valid_i,
    input  logic [X_ADDR_WIDTH-1:0] tx_dest_x_i,
    input  logic [Y_ADDR_WIDTH-1:0] tx_dest_y_i,
    input  logic [DATA_WIDTH-1:0]   tx_data_i,
    output logic                    tx_ready_o,
    output logic                    net_valid_o,
    output logic [DATA_WIDTH-1:0]   net_data_o,
    output logic [ADDR_WIDTH-1:0]   net_addr_o,
    input  logic                    net_ready_i,
    input  logic                    net_valid_i,
    input  logic [DATA_WIDTH-1:0]   net_data_i,
    input  logic [ADDR_WIDTH-1:0]   net_addr_i,
    output logic                    net_ready_o,
    output logic                    rx_valid_o,
    output logic [DATA_WIDTH-1:0]   rx_data_o,
    output logic [ADDR_WIDTH-1:0]   rx_addr_o,
    input  logic                    rx_ready_i,
    input  logic                    clear_i,
    output logic [COUNT_WIDTH-1:0]  tx_count_o,
    output logic [COUNT_WIDTH-1:0]  rx_count_o,
    output logic                    misroute_o,
    output logic                    stall_o
);

    localparam int TX_PW   = $clog2(TX_DEPTH);
    localparam int RX_PW   = $clog2(RX_DEPTH);
    localparam int PAD_W   = ADDR_WIDTH - X_ADDR_WIDTH - Y_ADDR_WIDTH;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [TX_PW:0]       TX_FULL   = (TX_PW + 1)'(TX_DEPTH);
    localparam logic [RX_PW:0]       RX_FULL   = (RX_PW + 1)'(RX_DEPTH);
    localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT);

    logic [ADDR_WIDTH-1:0]   tx_addr_mem [TX_DEPTH];
    logic [DATA_WIDTH-1:0]   tx_data_mem [TX_DEPTH];
    logic [TX_PW-1:0]        tx_wr_ptr;
    logic [TX_PW-1:0]        tx_rd_ptr;
    logic [TX_PW:0]          tx_cnt;

    logic [ADDR_WIDTH-1:0]   rx_addr_mem [RX_DEPTH];
    logic [DATA_WIDTH-1:0]   rx_data_mem [RX_DEPTH];
    logic [RX_PW-1:0]        rx_wr_ptr;
    logic [RX_PW-1:0]        rx_rd_ptr;
    logic [RX_PW:0]          rx_cnt;

    logic                    tx_push;
    logic                    tx_pop;
    logic                    rx_push;
    logic                    rx_pop;
    logic [ADDR_WIDTH-1:0]   tx_addr_packed;
    logic [X_ADDR_WIDTH-1:0] rx_x;
    logic [Y_ADDR_WIDTH-1:0] rx_y;
    logic                    rx_misrouted;
    logic [STALL_W-1:0]      stall_cnt;

    // Coordinates occupy the address MSBs, X above Y; any remaining low bits are zero.
    assign tx_addr_packed = ADDR_WIDTH'({tx_dest_x_i, tx_dest_y_i}) << PAD_W;
    assign rx_x           = net_addr_i[ADDR_WIDTH-1 -: X_ADDR_WIDTH];
    assign rx_y           = net_addr_i[ADDR_WIDTH-X_ADDR_WIDTH-1 -: Y_ADDR_WIDTH];
    assign rx_misrouted   = ({rx_x, rx_y} != {local_x_addr, local_y_addr});

    // Readies come only from registered occupancy, so the router's valid can depend on them safely.
    assign tx_ready_o  = (tx_cnt != TX_FULL);
    assign net_ready_o = (rx_cnt != RX_FULL);
    assign net_valid_o = (tx_cnt != '0);
    assign rx_valid_o  = (rx_cnt != '0);

    assign tx_push = tx_valid_i  && tx_ready_o;
    assign tx_pop  = net_valid_o && net_ready_i;
    assign rx_push = net_valid_i && net_ready_o;
    assign rx_pop  = rx_valid_o  && rx_ready_i;

    // Payload outputs are forced to zero while the matching valid is low.
    assign net_data_o = net_valid_o ? tx_data_mem[tx_rd_ptr] : '0;
    assign net_addr_o = net_valid_o ? tx_addr_mem[tx_rd_ptr] : '0;
    assign rx_data_o  = rx_valid_o  ? rx_data_mem[rx_rd_ptr] : '0;
    assign rx_addr_o  = rx_valid_o  ? rx_addr_mem[rx_rd_ptr] : '0;

    assign stall_o = (stall_cnt == STALL_MAX);

    // FIFO storage; contents need no reset because the outputs are masked by occupancy.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_addr_mem[tx_wr_ptr] <= tx_addr_packed;
            tx_data_mem[tx_wr_ptr] <= tx_data_i;
        end
        if (rx_push) begin
            rx_addr_mem[rx_wr_ptr] <= net_addr_i;
            rx_data_mem[rx_wr_ptr] <= net_data_i;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Saturating flit counters and sticky misroute flag; clear wins over a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_o <= '0;
            rx_count_o <= '0;
            misroute_o <= 1'b0;
        end else if (clear_i) begin
            tx_count_o <= '0;
            rx_count_o <= '0;
            misroute_o <= 1'b0;
        end else begin
            if (tx_pop && (tx_count_o != '1)) tx_count_o <= tx_count_o + 1'b1;
            if (rx_push && (rx_count_o != '1)) rx_count_o <= rx_count_o + 1'b1;
            if (rx_push && rx_misrouted) misroute_o <= 1'b1;
        end
    end

    // Injection-stall watchdog: counts blocked-head cycles, restarts whenever the head moves or TX drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!net_valid_o || tx_pop) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mesh_network_interface.sv
// Scoreboard bench for mesh_network_interface: expected flits are queued at drive time
// and compared as they leave the TX and RX sides; status outputs are checked at key points.
`timescale 1ns/1ps

module tb_mesh_network_interface;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [XW-1:0] local_x_addr = 4'd1;
    logic [YW-1:0] local_y_addr = 4'd1;
    logic          tx_valid_i = 1'b0;
    logic [XW-1:0] tx_dest_x_i = '0;
    logic [YW-1:0] tx_dest_y_i = '0;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_ready_o;
    logic          net_valid_o;
    logic [DW-1:0] net_data_o;
    logic [AW-1:0] net_addr_o;
    logic          net_ready_i = 1'b0;
    logic          net_valid_i = 1'b0;
    logic [DW-1:0] net_data_i = '0;
    logic [AW-1:0] net_addr_i = '0;
    logic          net_ready_o;
    logic          rx_valid_o;
    logic [DW-1:0] rx_data_o;
    logic [AW-1:0] rx_addr_o;
    logic          rx_ready_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [CW-1:0] tx_count_o;
    logic [CW-1:0] rx_count_o;
    logic          misroute_o;
    logic          stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+DW-1:0] tx_q[$];
    logic [AW+DW-1:0] rx_q[$];
    logic [AW+DW-1:0] exp_tx;
    logic [AW+DW-1:0] exp_rx;

    mesh_network_interface dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .local_x_addr (local_x_addr),
        .local_y_addr (local_y_addr),
        .tx_valid_i   (tx_valid_i),
        .tx_dest_x_i  (tx_dest_x_i),
        .tx_dest_y_i  (tx_dest_y_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .net_valid_o  (net_valid_o),
        .net_data_o   (net_data_o),
        .net_addr_o   (net_addr_o),
        .net_ready_i  (net_ready_i),
        .net_valid_i  (net_valid_i),
        .net_data_i   (net_data_i),
        .net_addr_i   (net_addr_i),
        .net_ready_o  (net_ready_o),
        .rx_valid_o   (rx_valid_o),
        .rx_data_o    (rx_data_o),
        .rx_addr_o    (rx_addr_o),
        .rx_ready_i   (rx_ready_i),
        .clear_i      (clear_i),
        .tx_count_o   (tx_count_o),
        .rx_count_o   (rx_count_o),
        .misroute_o   (misroute_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [AW-1:0] pack_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [AW-1:0] a;
        a = '0;
        a[AW-1 -: XW]    = x;
        a[AW-XW-1 -: YW] = y;
        return a;
    endfunction

    // TX side monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst_n && net_valid_o && net_ready_i) begin
            if (tx_q.size() == 0) begin
                check_eq("tx_unexpected_flit", {net_addr_o, net_data_o}, 0);
            end else begin
                exp_tx = tx_q.pop_front();
                check_eq("tx_flit", {net_addr_o, net_data_o}, exp_tx);
            end
        end
        if (rst_n && !net_valid_o) check_eq("tx_idle_zero", {net_addr_o, net_data_o}, 0);
    end

    // RX side monitor.
    always @(negedge clk) begin
        if (rst_n && rx_valid_o && rx_ready_i) begin
            if (rx_q.size() == 0) begin
                check_eq("rx_unexpected_flit", {rx_addr_o, rx_data_o}, 0);
            end else begin
                exp_rx = rx_q.pop_front();
                check_eq("rx_flit", {rx_addr_o, rx_data_o}, exp_rx);
            end
        end
        if (rst_n && !rx_valid_o) check_eq("rx_idle_zero", {rx_addr_o, rx_data_o}, 0);
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic tx_send(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [DW-1:0] d);
        bit took = 1'b0;
        int budget = 200;
        tx_valid_i  = 1'b1;
        tx_dest_x_i = x;
        tx_dest_y_i = y;
        tx_data_i   = d;
        tx_q.push_back({pack_addr(x, y), d});
        while (!took && budget > 0) begin
            @(negedge clk);
            took = tx_ready_o;
            @(posedge clk);
            #1;
            budget--;
        end
        tx_valid_i = 1'b0;
        if (!took) check_eq("tx_send_timeout", 0, 1);
    endtask

    task automatic rx_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit took = 1'b0;
        int budget = 200;
        net_valid_i = 1'b1;
        net_addr_i  = a;
        net_data_i  = d;
        rx_q.push_back({a, d});
        while (!took && budget > 0) begin
            @(negedge clk);
            took = net_ready_o;
            @(posedge clk);
            #1;
            budget--;
        end
        net_valid_i = 1'b0;
        if (!took) check_eq("rx_push_timeout", 0, 1);
    endtask

    task automatic wait_tx_empty();
        int budget = 100;
        while (net_valid_o && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check_eq("tx_drained", net_valid_o, 0);
    endtask

    task automatic wait_rx_empty();
        int budget = 100;
        while (rx_valid_o && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check_eq("rx_drained", rx_valid_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset values
        #2;
        check_eq("rst_tx_ready", tx_ready_o, 1);
        check_eq("rst_net_ready", net_ready_o, 1);
        check_eq("rst_net_valid", net_valid_o, 0);
        check_eq("rst_rx_valid", rx_valid_o, 0);
        check_eq("rst_net_payload", {net_addr_o, net_data_o}, 0);
        check_eq("rst_rx_payload", {rx_addr_o, rx_data_o}, 0);
        check_eq("rst_counts", {tx_count_o, rx_count_o}, 0);
        check_eq("rst_flags", {misroute_o, stall_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming TX with router always ready
        net_ready_i = 1'b1;
        rx_ready_i  = 1'b1;
        for (int i = 0; i < 4; i++) tx_send(4'd2, 4'd3, 32'hA0 + i);
        wait_tx_empty();
        check_eq("tx_count_4", tx_count_o, 4);

        // TX back-pressure: fill, then a 5th flit waits for a pop
        net_ready_i = 1'b0;
        check_eq("tx_empty_before", net_valid_o, 0);
        tx_send(4'd1, 4'd2, 32'hB0);
        check_eq("tx_latency_valid", net_valid_o, 1);
        check_eq("tx_latency_addr", net_addr_o, 8'h12);
        tx_send(4'd3, 4'd4, 32'hB1);
        tx_send(4'd5, 4'd6, 32'hB2);
        tx_send(4'd7, 4'd8, 32'hB3);
        check_eq("tx_full_ready", tx_ready_o, 0);
        fork
            tx_send(4'd9, 4'd10, 32'hB4);
            begin
                repeat (3) @(posedge clk);
                #1;
                check_eq("tx_fifth_held", tx_ready_o, 0);
                net_ready_i = 1'b1;
            end
        join
        wait_tx_empty();
        check_eq("tx_count_9", tx_count_o, 9);

        // RX: one local flit then one misrouted flit
        rx_push(8'h11, 32'hC0);
        check_eq("misroute_after_local", misroute_o, 0);
        rx_push(8'h12, 32'hC1);
        check_eq("misroute_after_bad", misroute_o, 1);
        wait_rx_empty();
        check_eq("rx_count_2", rx_count_o, 2);

        // RX fill with core stalled; ready recovers one cycle after a pop
        rx_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) rx_push(pack_addr(4'd1, 4'd1), 32'hD0 + i);
        check_eq("rx_full_ready", net_ready_o, 0);
        rx_ready_i = 1'b1;
        @(negedge clk);
        check_eq("rx_full_pop_same_cycle", net_ready_o, 0);
        @(posedge clk);
        #1;
        rx_ready_i = 1'b0;
        check_eq("rx_ready_after_pop", net_ready_o, 1);
        rx_ready_i = 1'b1;
        wait_rx_empty();
        check_eq("rx_count_6", rx_count_o, 6);
        check_eq("misroute_sticky", misroute_o, 1);

        // Stall watchdog at the STALL_LIMIT boundary
        net_ready_i = 1'b0;
        check_eq("stall_idle", stall_o, 0);
        tx_send(4'd3, 4'd3, 32'hE0);
        repeat (63) @(posedge clk);
        #1;
        check_eq("stall_at_63", stall_o, 0);
        @(posedge clk);
        #1;
        check_eq("stall_at_64", stall_o, 1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("stall_saturated", stall_o, 1);
        net_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("stall_after_pop", stall_o, 0);
        check_eq("tx_count_10", tx_count_o, 10);

        // Clear beats a same-cycle RX push and misroute set
        net_valid_i = 1'b1;
        net_addr_i  = pack_addr(4'd1, 4'd3);
        net_data_i  = 32'hF0;
        clear_i     = 1'b1;
        rx_q.push_back({pack_addr(4'd1, 4'd3), 32'hF0});
        @(negedge clk);
        check_eq("clear_push_ready", net_ready_o, 1);
        @(posedge clk);
        #1;
        net_valid_i = 1'b0;
        clear_i     = 1'b0;
        check_eq("clear_rx_count", rx_count_o, 0);
        check_eq("clear_tx_count", tx_count_o, 0);
        check_eq("clear_misroute", misroute_o, 0);
        rx_push(pack_addr(4'd1, 4'd1), 32'hF1);
        check_eq("rx_count_after_clear", rx_count_o, 1);
        wait_rx_empty();

        // Reset in the middle of a burst
        net_ready_i = 1'b0;
        rx_ready_i  = 1'b0;
        for (int i = 0; i < 3; i++) tx_send(4'd4, 4'd5, 32'h100 + i);
        for (int i = 0; i < 2; i++) rx_push(pack_addr(4'd2, 4'd2), 32'h200 + i);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_net_valid", net_valid_o, 0);
        check_eq("midrst_rx_valid", rx_valid_o, 0);
        check_eq("midrst_readies", {tx_ready_o, net_ready_o}, 2'b11);
        check_eq("midrst_payloads", {net_data_o, rx_data_o}, 0);
        check_eq("midrst_counts", {tx_count_o, rx_count_o}, 0);
        check_eq("midrst_misroute", misroute_o, 0);
        tx_q.delete();
        rx_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("postrst_empty", {net_valid_o, rx_valid_o}, 0);

        // Traffic resumes cleanly after reset
        net_ready_i = 1'b1;
        rx_ready_i  = 1'b1;
        tx_send(4'd1, 4'd1, 32'h300);
        rx_push(pack_addr(4'd1, 4'd1), 32'h301);
        wait_tx_empty();
        wait_rx_empty();
        check_eq("postrst_tx_count", tx_count_o, 1);
        check_eq("postrst_rx_count", rx_count_o, 1);
        check_eq("tx_scoreboard_empty", tx_q.size(), 0);
        check_eq("rx_scoreboard_empty", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
